// File: rtl/rgb2ycbcr.sv
// rgb2ycbcr: 3-stage pipelined RGB888 -> YCbCr888 converter (BT.601 full range, truncating).
// Optional output-side frame/line statistics are built when RGB2YCBCR_STATS_EN is defined.
module rgb2ycbcr #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_de,
    input  logic [23:0] in_data,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de,
    output logic [23:0] out_data,
    output logic [15:0] frame_cnt,
    output logic        fmt_err
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [COEF_W-1:0] C_Y_R  = 8'd77;
    localparam logic [COEF_W-1:0] C_Y_G  = 8'd150;
    localparam logic [COEF_W-1:0] C_Y_B  = 8'd29;
    localparam logic [COEF_W-1:0] C_CB_R = 8'd43;
    localparam logic [COEF_W-1:0] C_CB_G = 8'd85;
    localparam logic [COEF_W-1:0] C_CB_B = 8'd128;
    localparam logic [COEF_W-1:0] C_CR_R = 8'd128;
    localparam logic [COEF_W-1:0] C_CR_G = 8'd107;
    localparam logic [COEF_W-1:0] C_CR_B = 8'd21;

    // Chroma offset of 128 pre-scaled by 256 so Cb/Cr sums stay non-negative.
    localparam logic signed [SUM_W-1:0] C_OFS = SUM_W'(32768);

    if (H_DISP < 1 || H_DISP > 65535 || V_DISP < 1 || V_DISP > 65535) begin : g_cfg_check
        $error("rgb2ycbcr: H_DISP and V_DISP must lie in 1..65535");
    end

    function automatic logic [PROD_W-1:0] mul_u(input logic [DATA_W-1:0] x,
                                                input logic [COEF_W-1:0] c);
        return PROD_W'(x) * PROD_W'(c);
    endfunction

    function automatic logic signed [SUM_W-1:0] to_s(input logic [PROD_W-1:0] p);
        return $signed({1'b0, p});
    endfunction

    function automatic logic [DATA_W-1:0] trunc_byte(input logic signed [SUM_W-1:0] s);
        return DATA_W'(s >>> DATA_W);
    endfunction

    logic [DATA_W-1:0] r_in, g_in, b_in;
    assign {r_in, g_in, b_in} = in_data;

    // Stage 1: nine unsigned coefficient products plus sync/de.
    logic [PROD_W-1:0] yr_p1_q, yg_p1_q, yb_p1_q;
    logic [PROD_W-1:0] cbr_p1_q, cbg_p1_q, cbb_p1_q;
    logic [PROD_W-1:0] crr_p1_q, crg_p1_q, crb_p1_q;
    logic              hs_p1_q, vs_p1_q, vld_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yr_p1_q  <= '0;
            yg_p1_q  <= '0;
            yb_p1_q  <= '0;
            cbr_p1_q <= '0;
            cbg_p1_q <= '0;
            cbb_p1_q <= '0;
            crr_p1_q <= '0;
            crg_p1_q <= '0;
            crb_p1_q <= '0;
            hs_p1_q  <= 1'b1;
            vs_p1_q  <= 1'b1;
            vld_p1_q <= 1'b0;
        end else begin
            yr_p1_q  <= mul_u(r_in, C_Y_R);
            yg_p1_q  <= mul_u(g_in, C_Y_G);
            yb_p1_q  <= mul_u(b_in, C_Y_B);
            cbr_p1_q <= mul_u(r_in, C_CB_R);
            cbg_p1_q <= mul_u(g_in, C_CB_G);
            cbb_p1_q <= mul_u(b_in, C_CB_B);
            crr_p1_q <= mul_u(r_in, C_CR_R);
            crg_p1_q <= mul_u(g_in, C_CR_G);
            crb_p1_q <= mul_u(b_in, C_CR_B);
            hs_p1_q  <= in_hsync;
            vs_p1_q  <= in_vsync;
            vld_p1_q <= in_de;
        end
    end

    // Stage 2: signed sums; intermediates may wrap but every final sum lands in 0..65535.
    logic signed [SUM_W-1:0] ysum_p2_d, cbsum_p2_d, crsum_p2_d;
    logic signed [SUM_W-1:0] ysum_p2_q, cbsum_p2_q, crsum_p2_q;
    logic                    hs_p2_q, vs_p2_q, vld_p2_q;

    always_comb begin
        ysum_p2_d  = to_s(yr_p1_q) + to_s(yg_p1_q) + to_s(yb_p1_q);
        cbsum_p2_d = C_OFS + to_s(cbb_p1_q) - to_s(cbr_p1_q) - to_s(cbg_p1_q);
        crsum_p2_d = C_OFS + to_s(crr_p1_q) - to_s(crg_p1_q) - to_s(crb_p1_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ysum_p2_q  <= '0;
            cbsum_p2_q <= '0;
            crsum_p2_q <= '0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            vld_p2_q   <= 1'b0;
        end else begin
            ysum_p2_q  <= ysum_p2_d;
            cbsum_p2_q <= cbsum_p2_d;
            crsum_p2_q <= crsum_p2_d;
            hs_p2_q    <= hs_p1_q;
            vs_p2_q    <= vs_p1_q;
            vld_p2_q   <= vld_p1_q;
        end
    end

    // Stage 3: truncate to bits [15:8]; blanked pixels are zeroed.
    logic [23:0] data_p3_d, data_p3_q;
    logic        hs_p3_q, vs_p3_q, vld_p3_q;

    always_comb begin
        data_p3_d = '0;
        if (vld_p2_q) begin
            data_p3_d = {trunc_byte(ysum_p2_q), trunc_byte(cbsum_p2_q), trunc_byte(crsum_p2_q)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p3_q <= '0;
            hs_p3_q   <= 1'b1;
            vs_p3_q   <= 1'b1;
            vld_p3_q  <= 1'b0;
        end else begin
            data_p3_q <= data_p3_d;
            hs_p3_q   <= hs_p2_q;
            vs_p3_q   <= vs_p2_q;
            vld_p3_q  <= vld_p2_q;
        end
    end

    assign out_data  = data_p3_q;
    assign out_hsync = hs_p3_q;
    assign out_vsync = vs_p3_q;
    assign out_de    = vld_p3_q;

`ifdef RGB2YCBCR_STATS_EN
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        fmt_err_q, fmt_err_d;
    logic        seen_vs_q, seen_vs_d;
    logic        de_prev_q, vs_prev_q;
    logic        de_fall, vs_fall;

    assign de_fall = de_prev_q & ~vld_p3_q;
    assign vs_fall = vs_prev_q & ~vs_p3_q;

    // Counters saturate so an absurdly long run cannot wrap back onto a legal length.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        fmt_err_d   = fmt_err_q;
        seen_vs_d   = seen_vs_q;
        if (vld_p3_q) begin
            if (pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
        end else if (de_fall) begin
            pix_cnt_d = '0;
            if (pix_cnt_q != 16'(H_DISP)) fmt_err_d = 1'b1;
            if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
        end
        if (vs_fall) begin
            line_cnt_d = '0;
            seen_vs_d  = 1'b1;
            if (seen_vs_q) begin
                if (line_cnt_q != 16'(V_DISP)) fmt_err_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            fmt_err_q   <= 1'b0;
            seen_vs_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b1;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fmt_err_q   <= fmt_err_d;
            seen_vs_q   <= seen_vs_d;
            de_prev_q   <= vld_p3_q;
            vs_prev_q   <= vs_p3_q;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign fmt_err   = fmt_err_q;
`else
    assign frame_cnt = '0;
    assign fmt_err   = 1'b0;
`endif

endmodule

// File: doc/rgb2ycbcr.md
# rgb2ycbcr

Pipelined RGB888 → YCbCr888 converter (BT.601 full-range, 8-bit fixed-point coefficients). It sits directly downstream of the image generator in the colour-space-conversion simulation. It consumes that generator's hsync/vsync/de/24-bit pixel stream and re-emits an identically timed stream, 3 cycles later, with YCbCr pixels for the dump/compare stage.

## Interface
- H_DISP, 640, expected active pixels per line (used only by stats logic)
- V_DISP, 480, expected active lines per frame (used only by stats logic)
- clk  in  1  pixel clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- in_hsync  in  1  line sync, active-low
- in_vsync  in  1  frame sync, active-low
- in_de  in  1  pixel valid
- in_data  in  24  {R[23:16], G[15:8], B[7:0]}
- out_hsync  out  1  in_hsync delayed 3 cycles
- out_vsync  out  1  in_vsync delayed 3 cycles
- out_de  out  1  in_de delayed 3 cycles
- out_data  out  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- frame_cnt  out  16  completed frames (stats)
- fmt_err  out  1  sticky timing-format error (stats)

## Operation
- Equations, all unsigned 8-bit inputs, 17-bit signed intermediates:
  - Y = (77R + 150G + 29B) >> 8
  - Cb = (−43R − 85G + 128B + 32768) >> 8
  - Cr = (128R − 107G − 21B + 32768) >> 8
- Truncation only, no rounding. The coefficient sets sum to 256/0/0, so results lie in 0..255 with no clipping needed; bits [15:8] of each sum are taken.
- Stage 1: register nine 8×8 products (16-bit unsigned each), plus in_hsync/vsync/de.
- Stage 2: register three sums: Y sum, and Cb/Cr sums with +32768 offset.
- Stage 3: register [15:8] of each sum into out_data. out_data is forced to 0 when the stage-3 de is 0.
- Pipeline runs every cycle. No stall and no back-pressure; every input cycle is accepted.

## Timing
- Latency exactly 3 clk from in_* to out_* for data and all sync/de signals. Alignment is exact on every cycle.
- Reset values:
  - out_data=0, out_de=0, out_hsync=1, out_vsync=1
  - All pipeline stages cleared
  - frame_cnt=0, fmt_err=0
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). After release, the first 3 output cycles show the cleared pipeline (de=0); input is then followed normally.
- Back-to-back de cycles stream at 1 pixel/clk. Isolated single-cycle de pulses pass through unchanged.

## Configuration
- RGB2YCBCR_STATS_EN defined: stats logic is built, operating on the output side (out_de/out_vsync).
  - Pixel counter counts out_de high cycles within each run. On each out_de falling edge, a run length ≠ H_DISP sets fmt_err, and the line counter increments.
  - On each out_vsync falling edge: if a previous frame exists and line count ≠ V_DISP, fmt_err is set. The line counter clears, and frame_cnt increments (wraps at 65535→0).
  - The first vsync falling edge after reset only clears counters; it performs no check and does not increment frame_cnt.
  - fmt_err is sticky until reset.
- RGB2YCBCR_STATS_EN undefined: frame_cnt and fmt_err are tied to 0; no counters are synthesized; the datapath is identical.

## Test plan
- Reset, then in_de=1, in_data=24'hFFFFFF → 3 cycles later out_de=1, out_data=24'hFF8080.
- in_data=24'h000000, 24'hFF0000, 24'h0000FF on consecutive de cycles → out_data=24'h008080, 24'h4C55FF, 24'h1CFF6B on consecutive cycles, starting at cycle 3.
- Drive a full 800×525 frame from the generator. Each out_hsync/out_vsync/out_de edge must occur exactly 3 cycles after the matching in_* edge, and out_data must be 0 whenever out_de=0.
- Assert rst_n low mid-line with de active → out_de=0, out_data=0, out_hsync=out_vsync=1 within the same cycle. After release, out_de stays 0 for 3 cycles.
- With RGB2YCBCR_STATS_EN defined:
  - Run 3 correct 640×480 frames → frame_cnt=2 and fmt_err=0 after the 3rd vsync falling edge.
  - Then shorten one line to 639 pixels → fmt_err=1 at that line's de falling edge (+3 cycles), and it stays 1 until reset.
